// File: rtl/alu_issue_queue.sv
// alu_issue_queue: small FIFO between decode and the 8-bit clock-gated ALU.
// Buffers {A, B, ALUOp}, issues at most one op per cycle on registered
// outputs, pulses alu_enable only for real ops, and produces a response
// strobe/sequence number aligned with the ALU's registered result.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [2:0]       in_op,
  input  logic             alu_hold,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_enable,
  output logic             rsp_valid,
  output logic [SEQ_W-1:0] rsp_seq,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [SEQ_W-1:0] next_seq_reg;
  logic [SEQ_W-1:0] alu_seq_reg;
  logic [7:0]       alu_a_reg;
  logic [7:0]       alu_b_reg;
  logic [2:0]       alu_op_reg;
  logic             alu_enable_reg;
  logic             rsp_valid_reg;
  logic [SEQ_W-1:0] rsp_seq_reg;
  logic [CNT_W-1:0] issue_count_reg;
  state_t           state_reg;

  logic             push;
  logic             pop;
  logic [EW-1:0]    head_entry;

  // Handshake and occupancy: full blocks accepts even when a pop happens,
  // and an empty queue never bypasses straight to the ALU.
  always_comb begin
    in_ready   = (count_reg != CW'(DEPTH));
    push       = in_valid && in_ready;
    pop        = (count_reg != '0) && !alu_hold;
    count_next = count_reg + CW'(push) - CW'(pop);
    head_entry = mem[rd_ptr_reg];
  end

  // Queue storage; no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_a, in_b, in_op};
    end
  end

  // Pointers, occupancy and sequence tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      next_seq_reg    <= '0;
      alu_seq_reg     <= '0;
      issue_count_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        alu_seq_reg  <= next_seq_reg;
        next_seq_reg <= next_seq_reg + SEQ_W'(1);
        if (issue_count_reg != '1) begin
          issue_count_reg <= issue_count_reg + CNT_W'(1);
        end
      end
    end
  end

  // Issue stage: operands only change on a real issue so the ALU input
  // cone stays quiet while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
      alu_enable_reg <= 1'b0;
    end else begin
      alu_enable_reg <= pop;
      if (pop) begin
        {alu_a_reg, alu_b_reg, alu_op_reg} <= head_entry;
      end
    end
  end

  // Response stage: one cycle behind issue, matching the ALU's result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_seq_reg   <= '0;
    end else begin
      rsp_valid_reg <= alu_enable_reg;
      rsp_seq_reg   <= alu_seq_reg;
    end
  end

  // Activity state machine tracking idle, issuing and stalled phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (push) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (alu_hold && (count_reg != '0)) begin
            state_reg <= HOLD;
          end else if ((count_next == '0) && !alu_enable_reg && !rsp_valid_reg && !pop) begin
            state_reg <= IDLE;
          end
        end
        HOLD: begin
          if (!alu_hold) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output mapping; busy covers queued work plus anything still in the pipe.
  always_comb begin
    alu_a       = alu_a_reg;
    alu_b       = alu_b_reg;
    alu_op      = alu_op_reg;
    alu_enable  = alu_enable_reg;
    rsp_valid   = rsp_valid_reg;
    rsp_seq     = rsp_seq_reg;
    issue_count = issue_count_reg;
    busy        = (count_reg != '0) || alu_enable_reg || rsp_valid_reg
                  || (state_reg == HOLD);
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: latency, full/hold, streaming,
// reset flush, idle hold-off, sequence wrap and counter saturation.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       alu_hold;

  logic       in_ready, alu_enable, rsp_valid, busy;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] rsp_seq;
  logic [15:0] issue_count;

  logic       s_in_ready, s_alu_enable, s_rsp_valid, s_busy;
  logic [7:0] s_alu_a, s_alu_b;
  logic [2:0] s_alu_op;
  logic [3:0] s_rsp_seq;
  logic [1:0] s_issue_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4), .SEQ_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .alu_hold(alu_hold),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .rsp_valid(rsp_valid), .rsp_seq(rsp_seq), .busy(busy),
    .issue_count(issue_count)
  );

  alu_issue_queue #(.DEPTH(4), .SEQ_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .alu_hold(alu_hold),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .alu_enable(s_alu_enable),
    .rsp_valid(s_rsp_valid), .rsp_seq(s_rsp_seq), .busy(s_busy),
    .issue_count(s_issue_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    alu_hold = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [7:0] t2_a  [4];
  logic [7:0] t2_b  [4];
  logic [2:0] t2_op [4];
  int rsp_cnt;
  int last_seq;

  initial begin
    in_a = '0; in_b = '0; in_op = '0;
    t2_a  = '{8'd5, 8'd5, 8'd3, 8'd5};
    t2_b  = '{8'd3, 8'd3, 8'd3, 8'd3};
    t2_op = '{3'b001, 3'b010, 3'b110, 3'b111};

    // ---- reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_enable", alu_enable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_busy", busy, 0);
    check("rst_issue_count", issue_count, 0);

    // ---- single op latency: ADD 5+3
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd3; in_op = 3'b000;
    step();                       // edge k: push
    in_valid = 1'b0;
    check("lat_k_enable", alu_enable, 0);
    check("lat_k_busy", busy, 1);
    step();                       // edge k+1: issue
    check("lat_k1_enable", alu_enable, 1);
    check("lat_k1_a", alu_a, 5);
    check("lat_k1_b", alu_b, 3);
    check("lat_k1_op", alu_op, 0);
    check("lat_k1_rsp", rsp_valid, 0);
    step();                       // edge k+2: ALU captures
    check("lat_k2_enable", alu_enable, 0);
    check("lat_k2_rsp", rsp_valid, 1);
    check("lat_k2_seq", rsp_seq, 0);
    step();
    check("lat_k3_rsp", rsp_valid, 0);
    check("lat_busy_end", busy, 0);
    check("lat_issue_count", issue_count, 1);

    // ---- fill under hold, refuse 5th, drain back-to-back
    do_reset();
    alu_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = t2_a[i]; in_b = t2_b[i]; in_op = t2_op[i];
      step();
    end
    check("full_in_ready", in_ready, 0);
    in_a = 8'd9; in_b = 8'd9; in_op = 3'b000;
    step();                       // 5th push offered while full
    check("full_refused_ready", in_ready, 0);
    check("hold_no_enable", alu_enable, 0);
    in_valid = 1'b0;
    alu_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("drain%0d_enable", i), alu_enable, 1);
      check($sformatf("drain%0d_a", i), alu_a, t2_a[i]);
      check($sformatf("drain%0d_op", i), alu_op, t2_op[i]);
      if (i > 0) begin
        check($sformatf("drain%0d_rsp", i), rsp_valid, 1);
        check($sformatf("drain%0d_seq", i), rsp_seq, i - 1);
      end
    end
    step();
    check("drain_end_enable", alu_enable, 0);
    check("drain_last_rsp", rsp_valid, 1);
    check("drain_last_seq", rsp_seq, 3);
    step();
    check("drain_rsp_done", rsp_valid, 0);

    // ---- idle: operands hold the last issued NOR 5,3
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle%0d_enable", i), alu_enable, 0);
    end
    check("idle_a", alu_a, 5);
    check("idle_b", alu_b, 3);
    check("idle_op", alu_op, 3'b111);
    check("idle_busy", busy, 0);

    // ---- streaming at count=2
    do_reset();
    alu_hold = 1'b1; in_valid = 1'b1; in_b = 8'd1; in_op = 3'b011;
    in_a = 8'd0; step();
    in_a = 8'd1; step();
    alu_hold = 1'b0;
    for (int n = 0; n < 6; n++) begin
      in_a = 8'(n + 2);
      step();
      check($sformatf("stream%0d_enable", n), alu_enable, 1);
      check($sformatf("stream%0d_a", n), alu_a, n);
      check($sformatf("stream%0d_ready", n), in_ready, 1);
    end
    // grow to 3 queued, then issue with 3 still queued
    alu_hold = 1'b1; in_a = 8'd8; step();
    alu_hold = 1'b0; in_a = 8'd9; step();
    check("pre_rst_enable", alu_enable, 1);
    check("pre_rst_ready", in_ready, 1);

    // ---- reset mid-operation
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_enable", alu_enable, 0);
    check("midrst_rsp", rsp_valid, 0);
    check("midrst_a", alu_a, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 1);
    rsp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid || alu_enable) rsp_cnt++;
    end
    check("midrst_no_activity", rsp_cnt, 0);

    // ---- 17 ops: sequence wrap and counter saturation
    do_reset();
    in_valid = 1'b1; in_b = 8'd0; in_op = 3'b000;
    rsp_cnt = 0;
    last_seq = -1;
    for (int i = 0; i < 40; i++) begin
      in_a = 8'(i);
      if (i == 17) in_valid = 1'b0;
      step();
      if (rsp_valid) begin
        check($sformatf("wrap_seq%0d", rsp_cnt), rsp_seq, rsp_cnt % 16);
        last_seq = int'(rsp_seq);
        rsp_cnt++;
      end
    end
    check("wrap_rsp_count", rsp_cnt, 17);
    check("wrap_17th_seq", last_seq, 0);
    check("wrap_issue_count", issue_count, 17);
    check("sat_issue_count", s_issue_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder for the 8-bit clock-gated ALU.
- Buffers ALU operations (A, B, ALUOp) from the decode side in a small FIFO with a valid/ready handshake.
- Presents one operation per cycle on registered outputs. Pulses the ALU enable only in cycles that carry a real operation, so the ALU's clock-gating enable stays low when idle.
- Produces a response strobe and sequence number aligned to the cycle in which the ALU's registered result, zero and overflow are valid.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, minimum 2.
- SEQ_W, 4: width of the issue sequence number; wraps modulo 2^SEQ_W.
- CNT_W, 16: width of the saturating issued-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer has an operation
- in_ready  out  1  queue can accept; equals !full, combinational from the registered count
- in_a  in  8  operand A
- in_b  in  8  operand B
- in_op  in  3  ALUOp code (000 ADD to 111 NOR), passed through unchanged
- alu_hold  in  1  downstream stall; no issue while high
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_op  out  3  registered ALUOp to ALU
- alu_enable  out  1  registered; high for exactly one cycle per issued op
- rsp_valid  out  1  ALU result/zero/overflow valid this cycle
- rsp_seq  out  SEQ_W  sequence number of the op whose result is valid
- busy  out  1  count!=0 or alu_enable or rsp_valid
- issue_count  out  CNT_W  number of ops issued since reset; saturates at all-ones

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: count, read/write pointers, next_seq = 0. alu_a = 0, alu_b = 0, alu_op = 0. alu_enable = 0, rsp_valid = 0, rsp_seq = 0, issue_count = 0. State = IDLE.
- Reset mid-operation: all queued entries are discarded. An in-flight alu_enable or rsp_valid is cleared at that edge. No response is produced for dropped ops.
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b, in_op} at the write pointer. The write pointer wraps DEPTH-1 -> 0.
- Pop/issue condition: count != 0 && !alu_hold at the edge. On issue:
  - alu_a/alu_b/alu_op <= head entry
  - alu_enable <= 1
  - alu_seq_q <= next_seq, then next_seq <= next_seq + 1
  - issue_count increments unless already all-ones
- No issue: alu_enable <= 0. alu_a/alu_b/alu_op hold their previous values (no toggling, saves power in the ALU input cone).
- Full: in_ready = 0 at count == DEPTH, even if a pop happens that cycle. There is no full-cycle pass-through.
- Empty: no bypass. An op pushed at edge k is first issuable at edge k+1.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Latency, with an op accepted at edge k and no hold:
  - count = 1 after edge k
  - issued at edge k+1, so alu_enable and alu_* are valid in the cycle after k+1
  - ALU captures at edge k+2
  - rsp_valid = 1 and rsp_seq = that op's sequence number in the cycle after k+2
- Response pipeline: rsp_valid <= alu_enable; rsp_seq <= alu_seq_q. Back-to-back issue gives rsp_valid high on consecutive cycles with incrementing rsp_seq.
- alu_hold: sampled at the edge. A hold asserted in the cycle when alu_enable is already high does not cancel that op; it only blocks the next pop.
- State machine, registered and visible via busy:
  - IDLE: count == 0 and no op in flight.
  - RUN: issuing.
  - HOLD: alu_hold && count != 0.
  - Transitions: IDLE->RUN on first push. RUN->HOLD when alu_hold. HOLD->RUN when alu_hold is released. RUN->IDLE when the queue is empty and rsp_valid has drained.
- Wrap: rsp_seq wraps 2^SEQ_W-1 -> 0. issue_count saturates and does not wrap.

Test Plan:
- Reset, then push A=5, B=3, op=000 at edge k → alu_enable=1 with alu_a=5, alu_b=3 in the cycle after k+1; rsp_valid=1 with rsp_seq=0 in the cycle after k+2; ALU result = 8.
- Push 4 ops with alu_hold=1 → in_ready=0 after the 4th push and a 5th push is refused. Release hold → 4 consecutive alu_enable pulses, then rsp_seq 0,1,2,3 on consecutive cycles. Ops = SUB 5-3, AND, CMP 3==3, NOR; ALU results 2, 00000001, 1, 11111000.
- Continuous in_valid at steady state with count=2 → simultaneous push/pop each cycle, count stays 2, one alu_enable per cycle, no bubbles.
- Assert reset while 3 ops are queued and alu_enable=1 → next cycle count=0, alu_enable=0, rsp_valid=0, alu_a=0; no rsp_valid afterwards until new pushes.
- Idle 10 cycles after draining → alu_enable stays 0 and alu_a/alu_b/alu_op remain at the last issued values; busy=0.
- Issue 17 ops with SEQ_W=4 → 17th rsp_seq = 0; issue_count=17. With CNT_W=2, issue_count saturates at 3.
